// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: tracks IF predictions through ID/EX, checks them against the EX outcome,
// and emits predictor updates plus redirect/flush. Define BRU_STATS_EN to add branch/mispredict counters.
module branch_resolve_unit #(
  parameter int ADDR_W = 32
`ifdef BRU_STATS_EN
  , parameter int STAT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic              if_pred_taken,
  input  logic [ADDR_W-1:0] if_pred_dest,
  input  logic              ex_is_branch,
  input  logic              ex_taken,
  input  logic [ADDR_W-1:0] ex_target,
  output logic              ex_valid,
  output logic [ADDR_W-1:0] ex_pc,
  output logic              upd_op,
  output logic [ADDR_W-1:0] upd_pc,
  output logic [ADDR_W-1:0] upd_dest,
  output logic              upd_success,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush
`ifdef BRU_STATS_EN
  , output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispred
`endif
);

  localparam logic ST_RUN   = 1'b0;
  localparam logic ST_FLUSH = 1'b1;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  logic state;

  logic              s1_valid;
  logic [ADDR_W-1:0] s1_pc;
  logic              s1_pred_taken;
  logic [ADDR_W-1:0] s1_pred_dest;

  logic              s2_valid;
  logic              s2_done;
  logic [ADDR_W-1:0] s2_pc;
  logic              s2_pred_taken;
  logic [ADDR_W-1:0] s2_pred_dest;

  logic              flushing;
  logic              advance;
  logic              resolve;
  logic              dir_wrong;
  logic              tgt_wrong;
  logic              alias_hit;
  logic              mispredict;
  logic              issue_upd;
  logic [ADDR_W-1:0] correct_pc;

  // Resolution is gated off in FLUSH so the doomed younger instruction never reports.
  always_comb begin
    flushing   = (state == ST_FLUSH);
    advance    = ~stall & ~flushing;
    resolve    = ~flushing & s2_valid & ~s2_done;
    dir_wrong  = ex_is_branch & (s2_pred_taken != ex_taken);
    tgt_wrong  = ex_is_branch & s2_pred_taken & ex_taken & (s2_pred_dest != ex_target);
    alias_hit  = ~ex_is_branch & s2_pred_taken;
    mispredict = resolve & (dir_wrong | tgt_wrong | alias_hit);
    issue_upd  = resolve & ex_is_branch;
    correct_pc = (ex_is_branch & ex_taken) ? ex_target : (s2_pc + PC_STEP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN:   state <= mispredict ? ST_FLUSH : ST_RUN;
        ST_FLUSH: state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
    end
  end

  // The flush edge kills both slots even under stall; a held EX slot remembers it already resolved.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_pc         <= '0;
      s1_pred_taken <= 1'b0;
      s1_pred_dest  <= '0;
      s2_valid      <= 1'b0;
      s2_done       <= 1'b0;
      s2_pc         <= '0;
      s2_pred_taken <= 1'b0;
      s2_pred_dest  <= '0;
    end else if (flushing) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_done  <= 1'b0;
    end else if (advance) begin
      s1_valid      <= if_valid;
      s1_pc         <= if_pc;
      s1_pred_taken <= if_pred_taken;
      s1_pred_dest  <= if_pred_dest;
      s2_valid      <= s1_valid;
      s2_done       <= 1'b0;
      s2_pc         <= s1_pc;
      s2_pred_taken <= s1_pred_taken;
      s2_pred_dest  <= s1_pred_dest;
    end else if (resolve) begin
      s2_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_op      <= 1'b0;
      upd_pc      <= '0;
      upd_dest    <= '0;
      upd_success <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      flush       <= 1'b0;
    end else begin
      upd_op   <= issue_upd;
      redirect <= mispredict;
      flush    <= mispredict;
      if (issue_upd) begin
        upd_pc      <= s2_pc;
        upd_dest    <= ex_target;
        upd_success <= ex_taken;
      end
      if (mispredict) begin
        redirect_pc <= correct_pc;
      end
    end
  end

  assign ex_valid = s2_valid;
  assign ex_pc    = s2_pc;

`ifdef BRU_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = '1;
  localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

  // Counters step on the same edge that raises the matching pulse and stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      if (issue_upd && (stat_branches != STAT_MAX)) begin
        stat_branches <= stat_branches + STAT_ONE;
      end
      if (mispredict && (stat_mispred != STAT_MAX)) begin
        stat_mispred <= stat_mispred + STAT_ONE;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed branches push expected pulses, a negedge monitor pops them.
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_dest;
  logic        ex_is_branch;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        upd_op;
  logic [31:0] upd_pc;
  logic [31:0] upd_dest;
  logic        upd_success;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
`ifdef BRU_STATS_EN
  logic [15:0] stat_branches;
  logic [15:0] stat_mispred;
`endif

  typedef struct {
    logic        uo;
    logic [31:0] upc;
    logic [31:0] udest;
    logic        usucc;
    logic        rd;
    logic [31:0] rpc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   exp_upd  = 0;
  int   exp_red  = 0;

  branch_resolve_unit dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .if_valid(if_valid),
    .if_pc(if_pc),
    .if_pred_taken(if_pred_taken),
    .if_pred_dest(if_pred_dest),
    .ex_is_branch(ex_is_branch),
    .ex_taken(ex_taken),
    .ex_target(ex_target),
    .ex_valid(ex_valid),
    .ex_pc(ex_pc),
    .upd_op(upd_op),
    .upd_pc(upd_pc),
    .upd_dest(upd_dest),
    .upd_success(upd_success),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .flush(flush)
`ifdef BRU_STATS_EN
    , .stat_branches(stat_branches),
    .stat_mispred(stat_mispred)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic [31:0] pc, input logic pt, input logic [31:0] pd);
    if_valid      = v;
    if_pc         = pc;
    if_pred_taken = pt;
    if_pred_dest  = pd;
  endtask

  task automatic set_ex(input logic br, input logic tk, input logic [31:0] tgt);
    ex_is_branch = br;
    ex_taken     = tk;
    ex_target    = tgt;
  endtask

  task automatic push_exp(input logic uo, input logic [31:0] upc, input logic [31:0] udest,
                          input logic usucc, input logic rd, input logic [31:0] rpc);
    exp_t e;
    e.uo = uo; e.upc = upc; e.udest = udest; e.usucc = usucc; e.rd = rd; e.rpc = rpc;
    exp_q.push_back(e);
    if (uo) exp_upd++;
    if (rd) exp_red++;
  endtask

  // One instruction flows IF -> ID -> EX alone; expected pulse fields are given explicitly.
  task automatic run_branch(input logic [31:0] pc, input logic pt, input logic [31:0] pd,
                            input logic br, input logic tk, input logic [31:0] tgt,
                            input logic e_uo, input logic e_rd, input logic [31:0] e_rpc);
    apply_stimulus(1'b1, pc, pt, pd);
    step();
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0);
    step();
    set_ex(br, tk, tgt);
    if (e_uo || e_rd) push_exp(e_uo, pc, tgt, tk, e_rd, e_rpc);
    step();
    set_ex(1'b0, 1'b0, 32'h0);
    step();
    step();
  endtask

  always @(negedge clk) begin
    if (!rst && (upd_op || redirect || flush)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_pulse: got upd_op=%0b redirect=%0b flush=%0b expected no pulse",
                 upd_op, redirect, flush);
      end else begin
        mon_e = exp_q.pop_front();
        check_output("upd_op", upd_op, mon_e.uo);
        check_output("redirect", redirect, mon_e.rd);
        check_output("flush", flush, mon_e.rd);
        if (mon_e.uo) begin
          check_output("upd_pc", upd_pc, mon_e.upc);
          check_output("upd_dest", upd_dest, mon_e.udest);
          check_output("upd_success", upd_success, mon_e.usucc);
        end
        if (mon_e.rd) check_output("redirect_pc", redirect_pc, mon_e.rpc);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    stall = 1'b0;
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0);
    set_ex(1'b0, 1'b0, 32'h0);
    #1;
    check_output("rst_upd_op", upd_op, 0);
    check_output("rst_redirect", redirect, 0);
    check_output("rst_flush", flush, 0);
    check_output("rst_ex_valid", ex_valid, 0);
    check_output("rst_ex_pc", ex_pc, 0);
    step();
    step();
    rst = 1'b0;
    step();

    // Correctly predicted taken branch
    run_branch(32'h00400010, 1'b1, 32'h00400040, 1'b1, 1'b1, 32'h00400040, 1'b1, 1'b0, 32'h0);

    // Predicted not taken, actually taken, with younger instructions behind it
    apply_stimulus(1'b1, 32'h00400020, 1'b0, 32'h0);
    step();
    apply_stimulus(1'b1, 32'h00400024, 1'b1, 32'h00500000);
    step();
    set_ex(1'b1, 1'b1, 32'h00400100);
    push_exp(1'b1, 32'h00400020, 32'h00400100, 1'b1, 1'b1, 32'h00400100);
    apply_stimulus(1'b1, 32'h00400028, 1'b1, 32'h00500000);
    step();
    set_ex(1'b0, 1'b0, 32'h0);
    apply_stimulus(1'b1, 32'h0040002C, 1'b1, 32'h00500000);
    step();
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    check_output("ex_valid_after_flush", ex_valid, 0);
    step();
    @(negedge clk);
    check_output("ex_valid_if_suppressed", ex_valid, 0);
    step();

    // Asynchronous reset mid-run with both slots valid and a mispredict pending in EX
    apply_stimulus(1'b1, 32'h00400100, 1'b1, 32'h00400140);
    step();
    apply_stimulus(1'b1, 32'h00400104, 1'b0, 32'h0);
    step();
    set_ex(1'b1, 1'b0, 32'h00400180);
    #2;
    rst = 1'b1;
    #1;
    check_output("mid_rst_ex_valid", ex_valid, 0);
    check_output("mid_rst_ex_pc", ex_pc, 0);
    check_output("mid_rst_upd_op", upd_op, 0);
    check_output("mid_rst_redirect", redirect, 0);
    check_output("mid_rst_flush", flush, 0);
    check_output("mid_rst_upd_pc", upd_pc, 0);
    check_output("mid_rst_upd_dest", upd_dest, 0);
    check_output("mid_rst_upd_success", upd_success, 0);
    check_output("mid_rst_redirect_pc", redirect_pc, 0);
    exp_upd = 0;
    exp_red = 0;
    step();
    set_ex(1'b0, 1'b0, 32'h0);
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b0;
    step();
    step();
    @(negedge clk);
    check_output("ex_valid_after_rst", ex_valid, 0);

    // Reset landing in the FLUSH cycle discards the pending pulse
    apply_stimulus(1'b1, 32'h00400110, 1'b0, 32'h0);
    step();
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0);
    step();
    set_ex(1'b1, 1'b1, 32'h00400800);
    step();
    rst = 1'b1;
    #1;
    check_output("flush_rst_redirect", redirect, 0);
    check_output("flush_rst_flush", flush, 0);
    check_output("flush_rst_upd_op", upd_op, 0);
    exp_upd = 0;
    exp_red = 0;
    set_ex(1'b0, 1'b0, 32'h0);
    step();
    rst = 1'b0;
    step();

    // Normal operation resumes after reset
    run_branch(32'h00400200, 1'b1, 32'h00400240, 1'b1, 1'b1, 32'h00400240, 1'b1, 1'b0, 32'h0);
    // Predicted taken, not taken: fall through
    run_branch(32'h00400020, 1'b1, 32'h00400080, 1'b1, 1'b0, 32'h00400080, 1'b1, 1'b1, 32'h00400024);
    // Fall-through wraps past the top of the address space
    run_branch(32'hFFFFFFFC, 1'b1, 32'h00001000, 1'b1, 1'b0, 32'h00001000, 1'b1, 1'b1, 32'h00000000);
    // Direction right, target wrong
    run_branch(32'h00400050, 1'b1, 32'h00400090, 1'b1, 1'b1, 32'h004000A0, 1'b1, 1'b1, 32'h004000A0);
    // Correct not-taken
    run_branch(32'h00400060, 1'b0, 32'h0, 1'b1, 1'b0, 32'h00400200, 1'b1, 1'b0, 32'h0);
    // Alias hit on a non-branch: redirect without an update
    run_branch(32'h00400030, 1'b1, 32'h00400500, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h00400034);
    // Non-branch predicted not taken: silent
    run_branch(32'h00400070, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Stalled EX slot yields exactly one update
    apply_stimulus(1'b1, 32'h004000B0, 1'b1, 32'h004000C0);
    step();
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0);
    step();
    stall = 1'b1;
    set_ex(1'b1, 1'b1, 32'h004000C0);
    push_exp(1'b1, 32'h004000B0, 32'h004000C0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      check_output("stall_ex_pc", ex_pc, 32'h004000B0);
      check_output("stall_ex_valid", ex_valid, 1);
    end
    stall = 1'b0;
    set_ex(1'b0, 1'b0, 32'h0);
    step();
    step();

    // Mispredict under stall: pulse still issued, flush clears both slots
    apply_stimulus(1'b1, 32'h00400090, 1'b0, 32'h0);
    step();
    apply_stimulus(1'b1, 32'h00400094, 1'b0, 32'h0);
    step();
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0);
    stall = 1'b1;
    set_ex(1'b1, 1'b1, 32'h00400300);
    push_exp(1'b1, 32'h00400090, 32'h00400300, 1'b1, 1'b1, 32'h00400300);
    step();
    set_ex(1'b0, 1'b0, 32'h0);
    step();
    @(negedge clk);
    check_output("ex_valid_flush_under_stall", ex_valid, 0);
    stall = 1'b0;
    step();
    @(negedge clk);
    check_output("s1_cleared_under_stall", ex_valid, 0);
    step();
    step();
    step();

    check_output("pending_expected", exp_q.size(), 0);
`ifdef BRU_STATS_EN
    check_output("stat_branches", {16'h0, stat_branches}, exp_upd);
    check_output("stat_mispred", {16'h0, stat_mispred}, exp_red);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
